// File: rtl/cache_bank_arbiter_pkg.sv
// Shared types and defaults for the cache bank arbiter.
package cache_arb_pkg;

  localparam int NUM_CH_DEF   = 3;
  localparam int NUM_BANK_DEF = 4;
  localparam int OP_W_DEF     = 2;

  // Context fields are sized for the widest supported build (OP_W <= 8, NUM_CH <= 4).
  // Each instance slices them down to its own widths.
  localparam int OP_W_MAX = 8;
  localparam int CH_W_MAX = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } bank_state_e;

  typedef struct packed {
    logic [OP_W_MAX-1:0] op;
    logic [CH_W_MAX-1:0] ch_id;
  } bank_ctx_t;

endpackage

// File: rtl/cache_bank_arbiter_rr.sv
// Round-robin arbiter: search starts at the pointer, and the pointer moves past the winner on a grant.
module rr_arbiter #(
  parameter  int N  = 3,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] win;
  logic [PW-1:0] idx;
  logic          found;

  // First requester at or after the pointer, wrapping at N.
  always_comb begin
    grant = '0;
    win   = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx = PW'((int'(ptr_q) + i) % N);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        win        = idx;
      end
    end
  end

  // On a grant, the pointer moves to the slot after the winner.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) ptr_q <= '0;
    else if (advance && found) ptr_q <= (win == PW'(N - 1)) ? '0 : PW'(win + 1'b1);
  end

endmodule

// File: rtl/cache_bank_arbiter.sv
// Cache bank arbiter: per-bank round-robin grant, then an issue/wait/respond sequence,
// and completion pulses back to the owning channel.
// Optional: define CACHE_BANK_ARB_PERF_EN to add the perf_conflict_cnt stall counter.
module cache_bank_arbiter
  import cache_arb_pkg::*;
#(
  parameter  int NUM_CH   = NUM_CH_DEF,
  parameter  int NUM_BANK = NUM_BANK_DEF,
  parameter  int OP_W     = OP_W_DEF,
  localparam int BANK_W   = $clog2(NUM_BANK),
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic [NUM_CH-1:0]                  ch_req_valid,
  output logic [NUM_CH-1:0]                  ch_req_ready,
  input  logic [NUM_CH-1:0][OP_W-1:0]        ch_req_op,
  input  logic [NUM_CH-1:0][BANK_W-1:0]      ch_req_bank_id,
  output logic [NUM_BANK-1:0]                bank_req_valid,
  input  logic [NUM_BANK-1:0]                bank_req_ready,
  output logic [NUM_BANK-1:0][OP_W-1:0]      bank_req_op,
  output logic [NUM_BANK-1:0][CH_W-1:0]      bank_req_ch_id,
  input  logic [NUM_BANK-1:0]                bank_done,
  output logic [NUM_CH-1:0]                  ch_done,
  output logic [NUM_CH-1:0][BANK_W-1:0]      ch_done_bank_id
`ifdef CACHE_BANK_ARB_PERF_EN
  ,
  output logic [15:0]                        perf_conflict_cnt
`endif
);

  logic [NUM_BANK-1:0][NUM_CH-1:0]   cand;
  logic [NUM_BANK-1:0][NUM_CH-1:0]   grant;
  logic [NUM_BANK-1:0]               idle;
  logic [NUM_BANK-1:0]               resp;
  logic [NUM_BANK-1:0]               resp_sel;
  logic [NUM_BANK-1:0][CH_W_MAX-1:0] resp_ch;

  // Candidates: valid channels aimed at an idle bank. Gated by rstn so ready stays low in reset.
  always_comb begin
    cand = '0;
    for (int b = 0; b < NUM_BANK; b++)
      for (int c = 0; c < NUM_CH; c++)
        cand[b][c] = rstn && ch_req_valid[c] && idle[b] &&
                     (ch_req_bank_id[c] == BANK_W'(b));
  end

  // A channel targets only one bank, so OR-ing the per-bank grants gives at most one ready bit per channel.
  always_comb begin
    ch_req_ready = '0;
    for (int b = 0; b < NUM_BANK; b++) ch_req_ready = ch_req_ready | grant[b];
  end

  // Each channel retires its lowest-numbered responding bank. Other banks wait in RESP.
  always_comb begin
    ch_done         = '0;
    ch_done_bank_id = '0;
    resp_sel        = '0;
    for (int c = 0; c < NUM_CH; c++)
      for (int b = 0; b < NUM_BANK; b++)
        if (!ch_done[c] && resp[b] && resp_ch[b] == CH_W_MAX'(c)) begin
          ch_done[c]         = 1'b1;
          ch_done_bank_id[c] = BANK_W'(b);
          resp_sel[b]        = 1'b1;
        end
  end

  for (genvar b = 0; b < NUM_BANK; b++) begin : g_bank
    bank_state_e state_q;
    bank_ctx_t   ctx_q;
    bank_ctx_t   win_ctx;

    rr_arbiter #(.N(NUM_CH)) u_rr (
      .clk     (clk),
      .rstn    (rstn),
      .req     (cand[b]),
      .advance (|cand[b]),
      .grant   (grant[b])
    );

    // Mux out the winning channel's opcode and index for latching.
    always_comb begin
      win_ctx = '0;
      for (int c = 0; c < NUM_CH; c++)
        if (grant[b][c]) begin
          win_ctx.op    = OP_W_MAX'(ch_req_op[c]);
          win_ctx.ch_id = CH_W_MAX'(c);
        end
    end

    // Bank sequencer: grant -> issue until accepted -> wait for done -> hand back completion.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        state_q <= IDLE;
        ctx_q   <= '0;
      end else begin
        case (state_q)
          IDLE:    if (|grant[b]) begin
                     ctx_q   <= win_ctx;
                     state_q <= ISSUE;
                   end
          ISSUE:   if (bank_req_ready[b]) state_q <= WAIT;
          WAIT:    if (bank_done[b])      state_q <= RESP;
          RESP:    if (resp_sel[b])       state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end

    assign idle[b]           = (state_q == IDLE);
    assign resp[b]           = (state_q == RESP);
    assign resp_ch[b]        = ctx_q.ch_id;
    assign bank_req_valid[b] = (state_q == ISSUE);
    assign bank_req_op[b]    = ctx_q.op[OP_W-1:0];
    assign bank_req_ch_id[b] = ctx_q.ch_id[CH_W-1:0];
  end

`ifdef CACHE_BANK_ARB_PERF_EN
  logic [15:0] perf_q;

  // Count cycles in which some channel is left waiting. The counter saturates instead of wrapping.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) perf_q <= '0;
    else if (|(ch_req_valid & ~ch_req_ready) && perf_q != 16'hFFFF) perf_q <= perf_q + 16'd1;
  end

  assign perf_conflict_cnt = perf_q;
`endif

endmodule

// File: tb/tb_cache_bank_arbiter.sv
// Bench for cache_bank_arbiter: a transaction-level model checked on every negedge,
// plus directed scenarios with literal expectations.
module tb_cache_bank_arbiter;
  localparam int NC = 3;
  localparam int NB = 4;

  logic                  clk = 1'b0;
  logic                  rstn = 1'b0;
  logic [NC-1:0]         ch_req_valid = '0;
  logic [NC-1:0]         ch_req_ready;
  logic [NC-1:0][1:0]    ch_req_op = '0;
  logic [NC-1:0][1:0]    ch_req_bank_id = '0;
  logic [NB-1:0]         bank_req_valid;
  logic [NB-1:0]         bank_req_ready = '1;
  logic [NB-1:0][1:0]    bank_req_op;
  logic [NB-1:0][1:0]    bank_req_ch_id;
  logic [NB-1:0]         bank_done = '0;
  logic [NC-1:0]         ch_done;
  logic [NC-1:0][1:0]    ch_done_bank_id;
`ifdef CACHE_BANK_ARB_PERF_EN
  logic [15:0]           perf_conflict_cnt;
  bit                    force_now = 1'b0;
`endif

  cache_bank_arbiter dut (
    .clk             (clk),
    .rstn            (rstn),
    .ch_req_valid    (ch_req_valid),
    .ch_req_ready    (ch_req_ready),
    .ch_req_op       (ch_req_op),
    .ch_req_bank_id  (ch_req_bank_id),
    .bank_req_valid  (bank_req_valid),
    .bank_req_ready  (bank_req_ready),
    .bank_req_op     (bank_req_op),
    .bank_req_ch_id  (bank_req_ch_id),
    .bank_done       (bank_done),
    .ch_done         (ch_done),
    .ch_done_bank_id (ch_done_bank_id)
`ifdef CACHE_BANK_ARB_PERF_EN
    ,
    .perf_conflict_cnt (perf_conflict_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model of each bank's transaction: owner = -1 means the bank is free.
  // issued = the bank has accepted the request; fin = the bank reported done.
  int m_owner[NB];
  int m_op[NB];
  bit m_issued[NB];
  bit m_fin[NB];
  int m_ptr[NB];
  int m_perf;

  logic [NC-1:0] e_ready, e_done;
  logic [NB-1:0] e_bvalid, e_sel;
  int            e_win[NB];
  int            e_dbank[NC];

  // Compute expected outputs from the model and compare every cycle.
  always @(negedge clk) begin : compare
    bit got;
    int c;
    e_ready = '0; e_done = '0; e_sel = '0; e_bvalid = '0;
    for (int b = 0; b < NB; b++) e_win[b] = -1;
    for (int i = 0; i < NC; i++) e_dbank[i] = 0;
    if (rstn) begin
      for (int b = 0; b < NB; b++) begin
        got = 1'b0;
        if (m_owner[b] < 0)
          for (int k = 0; k < NC; k++) begin
            c = (m_ptr[b] + k) % NC;
            if (!got && ch_req_valid[c] && int'(ch_req_bank_id[c]) == b) begin
              got = 1'b1; e_ready[c] = 1'b1; e_win[b] = c;
            end
          end
        e_bvalid[b] = (m_owner[b] >= 0) && !m_issued[b];
      end
      for (int ch = 0; ch < NC; ch++)
        for (int b = 0; b < NB; b++)
          if (!e_done[ch] && m_fin[b] && m_owner[b] == ch) begin
            e_done[ch] = 1'b1; e_dbank[ch] = b; e_sel[b] = 1'b1;
          end
      chk("ch_req_ready", ch_req_ready, e_ready);
      chk("bank_req_valid", bank_req_valid, e_bvalid);
      chk("ch_done", ch_done, e_done);
      for (int b = 0; b < NB; b++)
        if (e_bvalid[b]) begin
          chk($sformatf("bank_req_op[%0d]", b), bank_req_op[b], m_op[b]);
          chk($sformatf("bank_req_ch_id[%0d]", b), bank_req_ch_id[b], m_owner[b]);
        end
      for (int ch = 0; ch < NC; ch++)
        if (e_done[ch]) chk($sformatf("ch_done_bank_id[%0d]", ch), ch_done_bank_id[ch], e_dbank[ch]);
    end else begin
      chk("rst_ch_req_ready", ch_req_ready, 0);
      chk("rst_bank_req_valid", bank_req_valid, 0);
      chk("rst_bank_req_op", bank_req_op, 0);
      chk("rst_bank_req_ch_id", bank_req_ch_id, 0);
      chk("rst_ch_done", ch_done, 0);
      chk("rst_ch_done_bank_id", ch_done_bank_id, 0);
    end
`ifdef CACHE_BANK_ARB_PERF_EN
    if (!force_now) chk("perf_conflict_cnt", perf_conflict_cnt, m_perf);
`endif
  end

  // Advance the model one transaction step per clock.
  always @(posedge clk or negedge rstn) begin : model
    if (!rstn) begin
      for (int b = 0; b < NB; b++) begin
        m_owner[b] = -1; m_op[b] = 0; m_issued[b] = 0; m_fin[b] = 0; m_ptr[b] = 0;
      end
      m_perf = 0;
    end else begin
`ifdef CACHE_BANK_ARB_PERF_EN
      if (force_now) m_perf = 65534;
`endif
      if (|(ch_req_valid & ~e_ready) && m_perf < 65535) m_perf++;
      for (int b = 0; b < NB; b++) begin
        if (e_sel[b]) begin
          m_owner[b] = -1; m_issued[b] = 0; m_fin[b] = 0;
        end else if (m_owner[b] >= 0 && m_issued[b] && !m_fin[b]) begin
          if (bank_done[b]) m_fin[b] = 1;
        end else if (m_owner[b] >= 0 && !m_issued[b]) begin
          if (bank_req_ready[b]) m_issued[b] = 1;
        end else if (m_owner[b] < 0 && e_win[b] >= 0) begin
          m_owner[b] = e_win[b];
          m_op[b]    = int'(ch_req_op[e_win[b]]);
          m_ptr[b]   = (e_win[b] + 1) % NC;
        end
      end
    end
  end

  task automatic half();
    @(negedge clk);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  function automatic int oh_idx(input logic [NC-1:0] v);
    for (int i = 0; i < NC; i++) if (v[i]) return i;
    return -1;
  endfunction

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    int order[4];
    int ngr;
    int dn;

    // Reset: a valid request must not see ready while reset is held.
    repeat (2) nxt();
    ch_req_valid = 3'b111;
    half();
    chk("reset_ready_gated", ch_req_ready, 3'b000);
    nxt();
    rstn = 1'b1;
    ch_req_valid = '0;
    nxt();

    // Single request: ch0 -> bank 2, op 1.
    ch_req_valid = 3'b001; ch_req_bank_id[0] = 2'd2; ch_req_op[0] = 2'd1;
    half(); chk("single_ready", ch_req_ready, 3'b001);
    nxt(); ch_req_valid = '0;
    half(); chk("single_bvalid", bank_req_valid, 4'b0100);
    chk("single_op", bank_req_op[2], 2'd1);
    chk("single_chid", bank_req_ch_id[2], 2'd0);
    nxt(); half(); chk("single_wait", bank_req_valid, 4'b0000);
    nxt(); nxt(); bank_done = 4'b0100;
    half(); chk("single_no_early_done", ch_done, 3'b000);
    nxt(); bank_done = '0;
    half(); chk("single_done", ch_done, 3'b001);
    chk("single_done_bank", ch_done_bank_id[0], 2'd2);
    nxt(); half(); chk("single_done_once", ch_done, 3'b000);
    nxt();

    // Contention: all three channels hammer bank 1; done returns 2 cycles after issue.
    ch_req_bank_id[0] = 2'd1; ch_req_bank_id[1] = 2'd1; ch_req_bank_id[2] = 2'd1;
    ch_req_op[0] = 2'd0; ch_req_op[1] = 2'd1; ch_req_op[2] = 2'd2;
    ch_req_valid = 3'b111;
    ngr = 0; dn = 0;
    for (int k = 0; k < 40; k++) begin
      half();
      if (ch_req_ready != '0 && ngr < 4) begin
        order[ngr] = oh_idx(ch_req_ready);
        ngr++;
      end
      if (bank_req_valid[1]) dn = 2;
      nxt();
      if (ngr >= 4) ch_req_valid = '0;
      bank_done = '0;
      if (dn > 0) begin
        dn--;
        if (dn == 0) bank_done[1] = 1'b1;
      end
    end
    bank_done = '0;
    chk("rr_grant_count", ngr, 4);
    chk("rr_order0", order[0], 0);
    chk("rr_order1", order[1], 1);
    chk("rr_order2", order[2], 2);
    chk("rr_order3", order[3], 0);

    // Ready stall on bank 3; bank 0 keeps working.
    bank_req_ready = 4'b0111;
    ch_req_valid = 3'b100; ch_req_bank_id[2] = 2'd3; ch_req_op[2] = 2'd2;
    half(); chk("stall_grant", ch_req_ready, 3'b100);
    nxt();
    ch_req_valid = 3'b011;
    ch_req_bank_id[0] = 2'd3; ch_req_op[0] = 2'd3;
    ch_req_bank_id[1] = 2'd0; ch_req_op[1] = 2'd1;
    for (int k = 0; k < 4; k++) begin
      half();
      chk("stall_bvalid3", bank_req_valid[3], 1'b1);
      chk("stall_op3", bank_req_op[3], 2'd2);
      chk("stall_chid3", bank_req_ch_id[3], 2'd2);
      chk("stall_no_regrant", ch_req_ready[0], 1'b0);
      if (k == 0) chk("stall_other_bank", ch_req_ready[1], 1'b1);
      nxt();
      if (k == 0) ch_req_valid = 3'b001;
      if (k == 3) begin bank_req_ready = 4'b1111; ch_req_valid = '0; end
    end
    half(); nxt();
    bank_done = 4'b1001;
    half(); nxt();
    bank_done = '0;
    half(); chk("stall_done_pair", ch_done, 3'b110);
    chk("stall_done_bank2", ch_done_bank_id[2], 2'd3);
    nxt();

    // Done collision: ch1 owns banks 0 and 2, both finish together.
    ch_req_valid = 3'b010; ch_req_bank_id[1] = 2'd0; ch_req_op[1] = 2'd1;
    half(); chk("coll_grant0", ch_req_ready, 3'b010);
    nxt(); ch_req_bank_id[1] = 2'd2; ch_req_op[1] = 2'd3;
    half(); chk("coll_grant2", ch_req_ready, 3'b010);
    nxt(); ch_req_valid = '0;
    nxt(); nxt(); bank_done = 4'b0101;
    nxt(); bank_done = '0;
    half(); chk("coll_done_a", ch_done, 3'b010);
    chk("coll_bank_a", ch_done_bank_id[1], 2'd0);
    nxt(); half(); chk("coll_done_b", ch_done, 3'b010);
    chk("coll_bank_b", ch_done_bank_id[1], 2'd2);
    nxt(); half(); chk("coll_quiet", ch_done, 3'b000);
    nxt();

    // Reset while bank 1 is waiting; a late done must be ignored.
    ch_req_valid = 3'b001; ch_req_bank_id[0] = 2'd1; ch_req_op[0] = 2'd2;
    half(); chk("rst_op_grant", ch_req_ready, 3'b001);
    nxt(); ch_req_valid = '0;
    nxt(); nxt();
    rstn = 1'b0; ch_req_valid = 3'b111;
    half(); chk("midrst_ready", ch_req_ready, 3'b000);
    chk("midrst_bvalid", bank_req_valid, 4'b0000);
    nxt(); rstn = 1'b1; ch_req_valid = '0;
    nxt(); bank_done = 4'b0010;
    half(); nxt(); bank_done = '0;
    half(); chk("midrst_no_done", ch_done, 3'b000);
    nxt();
    ch_req_valid = 3'b100; ch_req_bank_id[2] = 2'd1; ch_req_op[2] = 2'd1;
    half(); chk("midrst_regrant", ch_req_ready, 3'b100);
    nxt(); ch_req_valid = '0;
    half(); chk("midrst_bvalid1", bank_req_valid, 4'b0010);
    chk("midrst_chid1", bank_req_ch_id[1], 2'd2);
    nxt(); nxt(); bank_done = 4'b0010;
    nxt(); bank_done = '0;
    nxt(); nxt();

`ifdef CACHE_BANK_ARB_PERF_EN
    // Perf: two channels fight over bank 0, which never finishes.
    rstn = 1'b0;
    nxt(); rstn = 1'b1;
    ch_req_valid = 3'b011; ch_req_bank_id[0] = 2'd0; ch_req_bank_id[1] = 2'd0;
    nxt(); nxt(); nxt();
    ch_req_valid = '0;
    half(); chk("perf_three", perf_conflict_cnt, 16'd3);
    nxt();
    ch_req_valid = 3'b011;
    force dut.perf_q = 16'hFFFE;
    force_now = 1'b1;
    #1 release dut.perf_q;
    nxt(); force_now = 1'b0;
    nxt();
    half(); chk("perf_saturate", perf_conflict_cnt, 16'hFFFF);
    nxt(); ch_req_valid = '0;
`endif

    repeat (2) nxt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cache_bank_arbiter.md
Name: cache_bank_arbiter

Overview:
- Shares the cache data banks among the upstream request channels that feed the keep-order buffers.
- Each cycle, every idle bank picks one channel that targets it, using per-bank round-robin. The bank handshake is then sequenced: issue, wait for done, return completion.
- Completions go back to the owning channel as a single-cycle done pulse, one per channel per cycle, for the channel's ordering buffer to retire.

Parameters:
- NUM_CH, 3, number of upstream request channels (2..4)
- NUM_BANK, 4, number of cache banks (power of two, ≥2)
- OP_W, 2, request opcode width
- BANK_W, $clog2(NUM_BANK), bank index width (derived; not overridden)
- CH_W, $clog2(NUM_CH), channel index width (derived)

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- ch_req_valid  in  NUM_CH  per-channel request valid
- ch_req_ready  out  NUM_CH  per-channel accept (combinational grant)
- ch_req_op  in  NUM_CH*OP_W  per-channel opcode
- ch_req_bank_id  in  NUM_CH*BANK_W  per-channel target bank
- bank_req_valid  out  NUM_BANK  request to bank
- bank_req_ready  in  NUM_BANK  bank accepts request
- bank_req_op  out  NUM_BANK*OP_W  latched opcode
- bank_req_ch_id  out  NUM_BANK*CH_W  latched owning channel
- bank_done  in  NUM_BANK  single-cycle completion pulse from bank
- ch_done  out  NUM_CH  completion pulse to channel
- ch_done_bank_id  out  NUM_CH*BANK_W  bank that completed

Behaviour:
- Per-bank FSM with four states:
  - IDLE: candidates are channels with ch_req_valid=1 and bank_id==b. If any exist, the round-robin winner gets ch_req_ready=1 in the same cycle. Latch op and ch_id, then go to ISSUE.
  - ISSUE: bank_req_valid=1 and op/ch_id held stable until bank_req_ready=1, then go to WAIT.
  - WAIT: hold until bank_done=1, then go to RESP.
  - RESP: wait until selected for the channel done output, then go to IDLE.
- bank_done outside WAIT is ignored.
- Round-robin: the per-bank pointer resets to 0. On a grant the pointer becomes winner+1 mod NUM_CH; with no grant it is unchanged. Search order is pointer, pointer+1, and so on.
- A channel targets one bank per cycle, so at most one ready bit per channel is high. ch_req_ready=0 for any channel not granted, including one whose target bank is not IDLE.
- Minimum latency: accept cycle N; bank_req_valid high from N+1; with bank_req_ready=1 at N+1, WAIT from N+2. bank_done at cycle M gives RESP at M+1 and ch_done at M+1 (combinational from RESP). The bank is IDLE again at M+2.
- Done collision: several banks in RESP for the same channel resolve lowest bank index first. The others stay in RESP; nothing is dropped.
- Back-to-back: a bank returns to IDLE the cycle after its done is issued. It is not granted in the same cycle it leaves RESP.
- Reset, including mid-operation: all FSMs IDLE, pointers 0, latched fields 0. All outputs are 0 during reset. In-flight bank operations are discarded, and a late bank_done after reset is ignored because the bank is in IDLE.

Optional Feature:
- Macro CACHE_BANK_ARB_PERF_EN.
- Defined:
  - Adds output perf_conflict_cnt, 16 bits.
  - Increments by 1 each cycle in which at least one channel has ch_req_valid=1 and ch_req_ready=0.
  - Saturates at 16'hFFFF; reset value 0.
- Undefined: the port and counter are absent. Functional behaviour is identical.

Decomposition:
- Package cache_arb_pkg holds:
  - bank_state_e: IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3
  - default NUM_CH, NUM_BANK, OP_W constants
  - per-bank context struct {op, ch_id}
- Sub-module rr_arbiter, parameter N:
  - inputs req[N], advance; output grant one-hot
  - owns the pointer register; instantiated once per bank.

Test Plan:
- Single request: ch0 valid, bank 2, op 1 at cycle 5; bank_req_ready=1 → ch0 ready at 5; bank_req_valid[2] at 6 with op=1, ch_id=0. bank_done[2] at 9 → ch_done[0]=1 with bank_id=2 at 10.
- Contention: ch0, ch1, ch2 all target bank 1 continuously, done returns 2 cycles after issue → grant order 0,1,2,0; no channel is granted twice before the others.
- Ready stall: bank 3 holds bank_req_ready=0 for 4 cycles → bank_req_valid[3], op and ch_id stay stable; no new grant to bank 3; other banks are unaffected.
- Done collision: ch1 owns banks 0 and 2, and bank_done[0] and bank_done[2] fire in the same cycle → ch_done[1] pulses with bank_id=0, then bank_id=2 on the next cycle.
- Reset mid-op: rstn low while bank 1 is in WAIT, then bank_done[1] after release → all outputs 0 during reset; no ch_done; bank 1 accepts a new request.
- Perf (macro defined): ch0 and ch1 both target bank 0 for 3 cycles with done never returned → perf_conflict_cnt=3; saturation checked with a forced preload of 16'hFFFE.
